// File: rtl/dec_pkg.sv
// dec_pkg: shared FSM state type and parameter defaults for decoder_2to4_pulse
package dec_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam int PULSE_LEN_DEF = 4;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/dec_pulse_timer.sv
// dec_pulse_timer: pulse length timer, loads PULSE_LEN and counts down to zero
module dec_pulse_timer #(
  parameter int CNT_W = 8,
  parameter int PULSE_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= CNT_W'(PULSE_LEN);
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  assign last = cnt == CNT_W'(1);
endmodule

// File: rtl/decoder_2to4_pulse.sv
// decoder_2to4_pulse: handshaked 2-to-4 one-hot decoder holding each pulse PULSE_LEN cycles
// Optional DEC_STATS_EN adds the dec_cnt handshake counter.
module decoder_2to4_pulse
  import dec_pkg::*;
#(
  parameter int PULSE_LEN = PULSE_LEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [1:0] in,
  output logic [3:0] out,
  output logic out_valid
`ifdef DEC_STATS_EN
  ,
  output logic [CNT_W-1:0] dec_cnt
`endif
);
  state_t state, state_n;
  logic hs, last, hold, ov_n;
  logic [3:0] out_n;
  dec_pulse_timer #(.CNT_W(CNT_W), .PULSE_LEN(PULSE_LEN)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(hs),
    .last(last)
  );
  assign in_ready = ~rst & (state == IDLE | last);
  assign hs = in_valid & in_ready;
  assign hold = state == ACTIVE & ~last;
  always_comb begin
    state_n = hs ? ACTIVE : (state == ACTIVE && last) ? IDLE : state;
    out_n = hs ? 4'b0001 << in : hold ? out : 4'b0000;
    ov_n = hs | hold;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      out <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      out <= out_n;
      out_valid <= ov_n;
    end
`ifdef DEC_STATS_EN
  always_ff @(posedge clk)
    if (rst) dec_cnt <= '0;
    else if (hs) dec_cnt <= dec_cnt + CNT_W'(1);
`endif
endmodule

// File: tb/tb_decoder_2to4_pulse.sv
// tb_decoder_2to4_pulse: random and directed checks of two instances (PULSE_LEN 4 and 1) against a pulse model
module tb_decoder_2to4_pulse;
  logic clk = 1'b0, rst = 1'b1;
  logic va = 1'b0, vb = 1'b0;
  logic [1:0] ca = 2'd0, cb = 2'd0;
  logic ra, rb, ova, ovb;
  logic [3:0] oa, ob;
`ifdef DEC_STATS_EN
  logic [7:0] da, db;
`endif
  int vectors = 0, errors = 0;
  int rem [2] = '{0, 0};
  int cnt [2] = '{0, 0};
  int pl [2] = '{4, 1};
  logic [1:0] code [2];
  bit acc [2] = '{0, 0};
  always #5 clk = ~clk;
  decoder_2to4_pulse #(.PULSE_LEN(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .in(ca), .out(oa), .out_valid(ova)
`ifdef DEC_STATS_EN
    , .dec_cnt(da)
`endif
  );
  decoder_2to4_pulse #(.PULSE_LEN(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in(cb), .out(ob), .out_valid(ovb)
`ifdef DEC_STATS_EN
    , .dec_cnt(db)
`endif
  );
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Model: a pulse is a remaining-cycle count plus the code that started it.
  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      bit v, rdy;
      v = k ? vb : va;
      rdy = !rst && rem[k] <= 1;
      acc[k] = 0;
      if (rst) begin
        rem[k] = 0;
        cnt[k] = 0;
      end else if (v && rdy) begin
        rem[k] = pl[k];
        code[k] = k ? cb : ca;
        cnt[k] = (cnt[k] + 1) % 256;
        acc[k] = 1;
      end else if (rem[k] > 0) rem[k] = rem[k] - 1;
    end
  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      logic [3:0] eo;
      eo = rem[k] > 0 ? 4'b0001 << code[k] : 4'b0000;
      chk(k ? "b_ready" : "a_ready", {7'd0, k ? rb : ra}, {7'd0, !rst && rem[k] <= 1});
      chk(k ? "b_out" : "a_out", {4'd0, k ? ob : oa}, {4'd0, eo});
      chk(k ? "b_valid" : "a_valid", {7'd0, k ? ovb : ova}, {7'd0, rem[k] > 0});
`ifdef DEC_STATS_EN
      chk(k ? "b_cnt" : "a_cnt", k ? db : da, 8'(cnt[k]));
`endif
    end
  task automatic send(input logic [1:0] c);
    int n;
    va = 1'b1;
    ca = c;
    for (n = 0; n < 20 && !ra; n++) tick();
    if (n == 20) chk("send_timeout", 8'd0, 8'd1);
    tick();
  endtask
  initial begin
    tick();
    tick();
    chk("rst_out", {4'd0, oa}, 8'h00);
    chk("rst_ready", {7'd0, ra}, 8'h00);
    rst = 1'b0;
    #1;
    chk("idle_ready", {7'd0, ra}, 8'h01);
    send(2'b10);
    va = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("single_out", {4'd0, oa}, 8'h04);
      chk("single_valid", {7'd0, ova}, 8'h01);
      tick();
    end
    chk("single_end", {4'd0, oa}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      send(2'(k));
      chk("codes_out", {4'd0, oa}, 8'(4'b0001 << k));
    end
    va = 1'b0;
    repeat (5) tick();
    send(2'b01);
    va = 1'b1;
    ca = 2'b11;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_lo", {7'd0, ra}, 8'h00);
      chk("bp_out_old", {4'd0, oa}, 8'h02);
      tick();
    end
    chk("bp_ready_hi", {7'd0, ra}, 8'h01);
    chk("bp_no_gap", {4'd0, oa}, 8'h02);
    tick();
    chk("bp_out_new", {4'd0, oa}, 8'h08);
    va = 1'b0;
    repeat (6) tick();
    send(2'b10);
    va = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_out", {4'd0, oa}, 8'h00);
    chk("mrst_valid", {7'd0, ova}, 8'h00);
    chk("mrst_ready", {7'd0, ra}, 8'h00);
    rst = 1'b0;
    #1;
    chk("mrst_idle_ready", {7'd0, ra}, 8'h01);
    repeat (3) begin
      tick();
      chk("mrst_no_resume", {4'd0, oa}, 8'h00);
    end
    vb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cb = 2'(i % 4);
      #1;
      chk("pl1_ready", {7'd0, rb}, 8'h01);
      tick();
      chk("pl1_out", {4'd0, ob}, 8'(4'b0001 << (i % 4)));
    end
    vb = 1'b0;
    tick();
`ifdef DEC_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vb = 1'b1;
    repeat (257) tick();
    vb = 1'b0;
    chk("stats_257", db, 8'h01);
`endif
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 99) == 0;
      if (!(va && !acc[0])) begin
        va = $urandom_range(0, 2) != 0;
        ca = 2'($urandom);
      end
      if (!(vb && !acc[1])) begin
        vb = $urandom_range(0, 3) != 0;
        cb = 2'($urandom);
      end
      tick();
    end
    rst = 1'b0;
    va = 1'b0;
    vb = 1'b0;
    repeat (6) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/decoder_2to4_pulse.md
DECODER_2TO4_PULSE -- requirements
Module: decoder_2to4_pulse

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 4, meaning cycles each decoded one-hot output is held (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the pulse timer and the statistics counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: a 2-bit code is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the offered code this cycle.
REQ-007 SHALL have port in, input, 2 bits: the binary code, 00..11.
REQ-008 SHALL have port out, output, 4 bits: the one-hot decoded line, or 0000 when idle.
REQ-009 SHALL have port out_valid, output, 1 bit: out carries a decoded pulse.
REQ-010 SHALL have port dec_cnt, output, CNT_W bits, present only with DEC_STATS_EN: the number of codes accepted.

Function
REQ-011 SHALL accept a code on any rising edge where in_valid && in_ready, which is a handshake.
REQ-012 SHALL use FSM states IDLE and ACTIVE.
REQ-013 SHALL drive in_ready=1 in IDLE, and in ACTIVE only on the final pulse cycle (timer==1).
REQ-014 SHALL, on a handshake, register out = 1 << in and out_valid=1 from the next cycle, giving 1-cycle latency.
REQ-015 SHALL decode the code mapping as 00->0001, 01->0010, 10->0100, 11->1000; out SHALL never have more than one bit set.
REQ-016 SHALL, on a handshake, load the timer with PULSE_LEN, and in ACTIVE decrement the timer by 1 per cycle.
REQ-017 SHALL transition IDLE->ACTIVE on a handshake, and otherwise remain in IDLE with out=0000 and out_valid=0.
REQ-018 SHALL transition ACTIVE->IDLE when timer==1 and there is no handshake; out=0000 and out_valid=0 SHALL follow on the next cycle.
REQ-019 SHALL, on a handshake while timer==1 (back-to-back), stay in ACTIVE, reload the timer to PULSE_LEN, and switch out to the new one-hot with no gap cycle.
REQ-020 SHALL ignore in and in_valid while in_ready=0; the offered code SHALL remain pending at the source and no data SHALL be lost.
REQ-021 SHALL, with PULSE_LEN=1, hold every pulse for exactly 1 cycle and keep in_ready=1 continuously.
REQ-022 SHALL produce every output from a register, with no combinational path from in to out.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, set state=IDLE, timer=0, out=0000, out_valid=0, and dec_cnt=0 if present.
REQ-024 SHALL, during reset cycles, hold in_ready=0 and accept no handshake.
REQ-025 SHALL abort any pulse on a reset asserted mid-pulse; the aborted pulse SHALL not resume after reset.

Configuration
REQ-026 SHALL, with DEC_STATS_EN defined, include dec_cnt; dec_cnt SHALL increment by 1 per handshake and wrap from 2^CNT_W-1 to 0.
REQ-027 SHALL, without DEC_STATS_EN, omit the dec_cnt port and its logic entirely; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL place in shared package dec_pkg the state enum (IDLE, ACTIVE), the PULSE_LEN default constant, and the CNT_W default constant.
REQ-029 SHALL implement the timer (load, decrement, last flag) in sub-module dec_pulse_timer; the decode and FSM SHALL remain in the top module.

Verification
REQ-030 SHALL cover single pulse: PULSE_LEN=4, in=10, in_valid for 1 cycle -> out=0100 and out_valid=1 for exactly 4 cycles starting 1 cycle later, then 0000.
REQ-031 SHALL cover all codes: in=00,01,10,11 sequentially -> out=0001,0010,0100,1000, each for 4 cycles, no gaps, one-hot each cycle.
REQ-032 SHALL cover backpressure: in_valid held with in=11 during an in=01 pulse -> in_ready=0 for 3 cycles, 1 on the 4th; out goes 0010 then 1000 with no 0000 cycle between.
REQ-033 SHALL cover mid-pulse reset: rst=1 on pulse cycle 2 -> next cycle out=0000, out_valid=0, in_ready=0; after rst=0, IDLE with in_ready=1.
REQ-034 SHALL cover PULSE_LEN=1: in_valid held for 5 cycles with in cycling 00..11 -> in_ready stays 1 and out changes every cycle.
REQ-035 SHALL cover DEC_STATS_EN with CNT_W=8: 257 handshakes -> dec_cnt=1; without the macro, the build SHALL have no dec_cnt port.
